rv32i_multicycle_core: RTL and testbench

RV32I_MULTICYCLE_CORE -- requirements
Module: rv32i_multicycle_core

---
 rtl/rv32i_multicycle_core.sv | 269 ++++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_core.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_core.sv
// Multicycle RV32I subset core: FETCH/DECODE/EXECUTE/MEM/WB with ready/req memory handshakes.
// Illegal encodings, misaligned accesses or targets, and out-of-range register indices halt the core.
module rv32i_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] alu_result,
    output logic        retire,
    output logic        illegal
);

    localparam int IDXW = $clog2(NUM_REGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_alu, r_next_pc, r_load, r_dmem_addr, r_dmem_wdata;
    logic        r_imem_req, r_dmem_req, r_dmem_we, r_retire, r_illegal;
    logic [31:0] r_regs [NUM_REGS];

    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic [31:0] w_rs1_val, w_rs2_val, w_opb, w_alu, w_pc4;
    logic        w_legal, w_use_rd, w_use_rs1, w_use_rs2, w_bad_reg, w_taken;

    assign w_opcode  = r_ir[6:0];
    assign w_rd      = r_ir[11:7];
    assign w_funct3  = r_ir[14:12];
    assign w_rs1     = r_ir[19:15];
    assign w_rs2     = r_ir[24:20];
    assign w_funct7  = r_ir[31:25];
    assign w_imm_i   = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s   = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b   = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_j   = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_imm_u   = {r_ir[31:12], 12'b0};
    assign w_pc4     = r_pc + 32'd4;

    // x0 is never written, but the read is forced to zero so it cannot depend on that.
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1[IDXW-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2[IDXW-1:0]];
    assign w_opb     = (w_opcode == OPC_OP) ? w_rs2_val : w_imm_i;
    assign w_shamt   = w_opb[4:0];
    assign w_bad_reg = (w_use_rd  && int'(w_rd)  >= NUM_REGS) ||
                       (w_use_rs1 && int'(w_rs1) >= NUM_REGS) ||
                       (w_use_rs2 && int'(w_rs2) >= NUM_REGS);

    always_comb begin
        w_legal   = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_legal   = (w_funct7 == 7'd0) ||
                            (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                if (w_funct3 == 3'b001)
                    w_legal = (w_funct7 == 7'd0);
                else if (w_funct3 == 3'b101)
                    w_legal = (w_funct7 == 7'd0) || (w_funct7 == 7'b0100000);
                else
                    w_legal = 1'b1;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            OPC_LUI, OPC_JAL: begin
                w_legal  = 1'b1;
                w_use_rd = 1'b1;
            end
            OPC_LOAD: begin
                w_legal   = (w_funct3 == 3'b010);
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                w_legal   = (w_funct3 == 3'b010);
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                w_legal   = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                            (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // For loads/stores the ALU produces the address, for branches/JAL the target.
    always_comb begin
        w_alu   = 32'd0;
        w_taken = 1'b0;
        case (w_opcode)
            OPC_OP, OPC_OPIMM: begin
                case (w_funct3)
                    3'b000:  w_alu = (w_opcode == OPC_OP && w_funct7[5]) ? w_rs1_val - w_opb
                                                                          : w_rs1_val + w_opb;
                    3'b001:  w_alu = w_rs1_val << w_shamt;
                    3'b010:  w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_opb)};
                    3'b011:  w_alu = {31'd0, w_rs1_val < w_opb};
                    3'b100:  w_alu = w_rs1_val ^ w_opb;
                    3'b101:  w_alu = w_funct7[5] ? 32'($signed(w_rs1_val) >>> w_shamt)
                                                 : w_rs1_val >> w_shamt;
                    3'b110:  w_alu = w_rs1_val | w_opb;
                    default: w_alu = w_rs1_val & w_opb;
                endcase
            end
            OPC_LUI:    w_alu = w_imm_u;
            OPC_JAL:    w_alu = r_pc + w_imm_j;
            OPC_LOAD:   w_alu = w_rs1_val + w_imm_i;
            OPC_STORE:  w_alu = w_rs1_val + w_imm_s;
            OPC_BRANCH: w_alu = r_pc + w_imm_b;
            default:    w_alu = 32'd0;
        endcase
        case (w_funct3)
            3'b000:  w_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
            3'b101:  w_taken = !($signed(w_rs1_val) < $signed(w_rs2_val));
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= 32'd0;
            r_alu        <= 32'd0;
            r_next_pc    <= 32'd0;
            r_load       <= 32'd0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_retire     <= 1'b0;
            r_illegal    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (r_imem_req && imem_ready) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    if (!w_legal || w_bad_reg) begin
                        r_illegal <= 1'b1;
                        r_state   <= HALT;
                    end else begin
                        r_state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    r_alu     <= w_alu;
                    r_next_pc <= w_pc4;
                    case (w_opcode)
                        OPC_LOAD, OPC_STORE: begin
                            if (w_alu[1:0] != 2'b00) begin
                                r_illegal <= 1'b1;
                                r_state   <= HALT;
                            end else begin
                                r_dmem_req   <= 1'b1;
                                r_dmem_we    <= (w_opcode == OPC_STORE);
                                r_dmem_addr  <= w_alu;
                                r_dmem_wdata <= w_rs2_val;
                                r_state      <= MEM;
                            end
                        end
                        OPC_BRANCH: begin
                            if (w_taken && w_alu[1]) begin
                                r_illegal <= 1'b1;
                                r_state   <= HALT;
                            end else begin
                                r_pc       <= w_taken ? w_alu : w_pc4;
                                r_imem_req <= 1'b1;
                                r_retire   <= 1'b1;
                                r_state    <= FETCH;
                            end
                        end
                        OPC_JAL: begin
                            if (w_alu[1]) begin
                                r_illegal <= 1'b1;
                                r_state   <= HALT;
                            end else begin
                                r_alu     <= w_pc4;
                                r_next_pc <= w_alu;
                                r_state   <= WB;
                            end
                        end
                        default: r_state <= WB;
                    endcase
                end
                MEM: begin
                    if (r_dmem_req && dmem_ready) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) begin
                            r_pc       <= r_next_pc;
                            r_imem_req <= 1'b1;
                            r_retire   <= 1'b1;
                            r_state    <= FETCH;
                        end else begin
                            r_load  <= dmem_rdata;
                            r_state <= WB;
                        end
                    end
                end
                WB: begin
                    if (w_rd != 5'd0)
                        r_regs[w_rd[IDXW-1:0]] <= (w_opcode == OPC_LOAD) ? r_load : r_alu;
                    r_pc       <= r_next_pc;
                    r_imem_req <= 1'b1;
                    r_retire   <= 1'b1;
                    r_state    <= FETCH;
                end
                HALT:    r_state <= HALT;
                default: r_state <= HALT;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign pc_out     = r_pc;
    assign alu_result = r_alu;
    assign retire     = r_retire;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Directed bench for rv32i_multicycle_core: small programs with hand-computed results and cycle counts.
module tb_rv32i_multicycle_core;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imemReq, imemReady, dmemReq, dmemWe, dmemReady, retire, illegal;
    logic [31:0] imemAddr, imemRdata, dmemAddr, dmemWdata, dmemRdata, pcOut, aluResult;

    logic        imemReq16, imemReady16, dmemReq16, dmemWe16, dmemReady16, retire16, illegal16;
    logic [31:0] imemAddr16, imemRdata16, dmemAddr16, dmemWdata16, dmemRdata16, pcOut16, aluResult16;

    logic [31:0] imem   [64];
    logic [31:0] imem16 [64];
    logic [31:0] dmem   [64];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          dmemDelay = 0;
    int          dmemCnt   = 0;
    bit          dmemActive, dmemUnstable, dmemReqSeen;
    logic [31:0] holdAddr, holdData, lastWAddr, lastWData;
    logic        holdWe;

    rv32i_multicycle_core #(.RESET_PC(32'h0000_0000), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_ready(imemReady), .imem_rdata(imemRdata),
        .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_addr(dmemAddr), .dmem_wdata(dmemWdata),
        .dmem_ready(dmemReady), .dmem_rdata(dmemRdata),
        .pc_out(pcOut), .alu_result(aluResult), .retire(retire), .illegal(illegal)
    );

    rv32i_multicycle_core #(.RESET_PC(32'h0000_0100), .NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst),
        .imem_req(imemReq16), .imem_addr(imemAddr16), .imem_ready(imemReady16), .imem_rdata(imemRdata16),
        .dmem_req(dmemReq16), .dmem_we(dmemWe16), .dmem_addr(dmemAddr16), .dmem_wdata(dmemWdata16),
        .dmem_ready(dmemReady16), .dmem_rdata(dmemRdata16),
        .pc_out(pcOut16), .alu_result(aluResult16), .retire(retire16), .illegal(illegal16)
    );

    assign imemRdata   = imem[imemAddr[7:2]];
    assign imemRdata16 = imem16[imemAddr16[7:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory responder: grants after dmemDelay stalled cycles and watches request stability.
    always @(negedge clk) begin
        if (!rst || !dmemReq) begin
            dmemReady  = 1'b0;
            dmemCnt    = 0;
            dmemActive = 1'b0;
        end else begin
            dmemReqSeen = 1'b1;
            if (!dmemActive) begin
                dmemActive = 1'b1;
                holdAddr   = dmemAddr;
                holdData   = dmemWdata;
                holdWe     = dmemWe;
            end else if (dmemAddr !== holdAddr || dmemWdata !== holdData || dmemWe !== holdWe) begin
                dmemUnstable = 1'b1;
            end
            if (dmemCnt >= dmemDelay) begin
                dmemReady = 1'b1;
                if (dmemWe) begin
                    dmem[dmemAddr[7:2]] = dmemWdata;
                    lastWAddr = dmemAddr;
                    lastWData = dmemWdata;
                end else begin
                    dmemRdata = dmem[dmemAddr[7:2]];
                end
            end else begin
                dmemReady = 1'b0;
                dmemCnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic waitRetire(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (retire === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'd0;
            dmem[i] = 32'd0;
        end
        dmemDelay    = 0;
        dmemUnstable = 1'b0;
        dmemReqSeen  = 1'b0;
        lastWAddr    = 32'hDEAD_BEEF;
        lastWData    = 32'hDEAD_BEEF;
    endtask

    // Reset is released on a falling edge; cycle 0 is the first clock cycle after release.
    task automatic doReset();
        rst       = 1'b0;
        imemReady = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cyc = -1;
    endtask

    task automatic test_reset();
        clearMem();
        imem[0] = NOP;
        rst       = 1'b0;
        imemReady = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (pcOut !== 32'd0 || imemReq !== 1'b0 || dmemReq !== 1'b0 || dmemWe !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs pc=%h imem_req=%b dmem_req=%b dmem_we=%b, want 0/0/0/0",
                     pcOut, imemReq, dmemReq, dmemWe);
        end
        total++;
        if (retire !== 1'b0 || illegal !== 1'b0 || aluResult !== 32'd0) begin
            bad++;
            $display("FAIL reset_status retire=%b illegal=%b alu=%h, want 0/0/0", retire, illegal, aluResult);
        end
        rst = 1'b1;
        cyc = -1;
        step();
        total++;
        if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin
            bad++;
            $display("FAIL first_fetch imem_req=%b addr=%h, want 1/00000000", imemReq, imemAddr);
        end
    endtask

    task automatic test_alu_program();
        bit ok;
        clearMem();
        imem[0] = 32'h0050_0093;   // ADDI x1,x0,5
        imem[1] = 32'h0010_8133;   // ADD  x2,x1,x1
        doReset();
        waitRetire(30, ok);
        total++;
        if (!ok || cyc !== 4 || aluResult !== 32'd5) begin
            bad++;
            $display("FAIL addi_retire ok=%b cycle=%0d alu=%0d, want cycle 4 alu 5", ok, cyc, aluResult);
        end
        waitRetire(30, ok);
        total++;
        if (!ok || cyc !== 8 || aluResult !== 32'd10 || pcOut !== 32'd8) begin
            bad++;
            $display("FAIL add_retire ok=%b cycle=%0d alu=%0d pc=%h, want cycle 8 alu 10 pc 8",
                     ok, cyc, aluResult, pcOut);
        end
    endtask

    task automatic test_mem_stall();
        bit ok;
        int prev;
        clearMem();
        imem[0] = 32'h0050_0093;   // ADDI x1,x0,5
        imem[1] = 32'h0010_8133;   // ADD  x2,x1,x1
        imem[2] = 32'h0020_2023;   // SW   x2,0(x0)
        imem[3] = 32'h0000_2183;   // LW   x3,0(x0)
        imem[4] = 32'h0001_8233;   // ADD  x4,x3,x0
        dmemDelay = 3;
        doReset();
        waitRetire(30, ok);
        waitRetire(30, ok);
        prev = cyc;
        waitRetire(40, ok);
        total++;
        if (!ok || cyc - prev !== 7 || lastWData !== 32'd10 || lastWAddr !== 32'd0) begin
            bad++;
            $display("FAIL sw_stalled ok=%b cycles=%0d wdata=%h waddr=%h, want 7 cycles 0000000a @0",
                     ok, cyc - prev, lastWData, lastWAddr);
        end
        prev = cyc;
        waitRetire(40, ok);
        total++;
        if (!ok || cyc - prev !== 8) begin
            bad++;
            $display("FAIL lw_latency ok=%b cycles=%0d, want 8", ok, cyc - prev);
        end
        waitRetire(30, ok);
        total++;
        if (!ok || aluResult !== 32'd10) begin
            bad++;
            $display("FAIL lw_value ok=%b x3+x0=%h, want 0000000a", ok, aluResult);
        end
        total++;
        if (dmemUnstable !== 1'b0) begin
            bad++;
            $display("FAIL dmem_stable changed_while_stalled=%b, want 0", dmemUnstable);
        end
    endtask

    task automatic test_branch();
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            clearMem();
            for (int i = 0; i < 4; i++) imem[i] = NOP;
            imem[4] = (pass == 0) ? 32'hFE00_0CE3 : 32'hFE00_1CE3;   // BEQ / BNE x0,x0,-8
            doReset();
            for (int i = 0; i < 4; i++) waitRetire(30, ok);
            waitRetire(30, ok);
            total++;
            if (!ok || cyc !== 19 || pcOut !== ((pass == 0) ? 32'h8 : 32'h14)) begin
                bad++;
                $display("FAIL branch_%s ok=%b cycle=%0d pc=%h, want cycle 19 pc %h",
                         (pass == 0) ? "beq" : "bne", ok, cyc, pcOut, (pass == 0) ? 32'h8 : 32'h14);
            end
        end
    endtask

    task automatic test_shift_compare();
        bit ok;
        logic [31:0] expect3 [3];
        expect3[0] = 32'h7FFF_FFFF;
        expect3[1] = 32'hFFFF_FFFF;
        expect3[2] = 32'h0000_0001;
        clearMem();
        imem[0] = 32'hFFF0_0093;   // ADDI x1,x0,-1
        imem[1] = 32'h0010_0293;   // ADDI x5,x0,1
        imem[2] = 32'h0050_D133;   // SRL  x2,x1,x5
        imem[3] = 32'h4050_D1B3;   // SRA  x3,x1,x5
        imem[4] = 32'h0010_3233;   // SLTU x4,x0,x1
        doReset();
        waitRetire(30, ok);
        waitRetire(30, ok);
        for (int k = 0; k < 3; k++) begin
            waitRetire(30, ok);
            total++;
            if (!ok || aluResult !== expect3[k]) begin
                bad++;
                $display("FAIL shift_cmp_%0d ok=%b alu=%h, want %h", k, ok, aluResult, expect3[k]);
            end
        end
    endtask

    task automatic test_pc_wrap();
        bit ok;
        clearMem();
        imem[0]  = 32'hFFDF_F0EF;   // JAL  x1,-4
        imem[63] = 32'h0000_8313;   // ADDI x6,x1,0 at 0xFFFFFFFC
        doReset();
        waitRetire(30, ok);
        total++;
        if (!ok || cyc !== 4 || pcOut !== 32'hFFFF_FFFC || aluResult !== 32'd4) begin
            bad++;
            $display("FAIL jal ok=%b cycle=%0d pc=%h alu=%h, want 4 fffffffc 00000004", ok, cyc, pcOut, aluResult);
        end
        waitRetire(30, ok);
        total++;
        if (!ok || pcOut !== 32'h0 || aluResult !== 32'd4) begin
            bad++;
            $display("FAIL pc_wrap ok=%b pc=%h x1=%h, want 00000000 00000004", ok, pcOut, aluResult);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        int extra;
        for (int pass = 0; pass < 2; pass++) begin
            clearMem();
            if (pass == 0) begin
                imem[0] = 32'h0070_0093;   // ADDI x1,x0,7 then opcode 0
            end else begin
                imem[0] = 32'h0020_0093;   // ADDI x1,x0,2
                imem[1] = 32'h0000_A183;   // LW   x3,0(x1)
            end
            doReset();
            waitRetire(30, ok);
            extra = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (retire === 1'b1) extra++;
            end
            total++;
            if (!ok || illegal !== 1'b1 || pcOut !== 32'h4 || extra !== 0) begin
                bad++;
                $display("FAIL illegal_%0d ok=%b illegal=%b pc=%h retires=%0d, want 1 00000004 0",
                         pass, ok, illegal, pcOut, extra);
            end
            total++;
            if (imemReq !== 1'b0 || dmemReq !== 1'b0 || dmemReqSeen !== 1'b0) begin
                bad++;
                $display("FAIL halt_quiet_%0d imem_req=%b dmem_req=%b dmem_seen=%b, want 0/0/0",
                         pass, imemReq, dmemReq, dmemReqSeen);
            end
        end
    endtask

    task automatic test_regs16();
        int firstRetire = -1;
        clearMem();
        doReset();
        for (int i = 0; i < 20; i++) begin
            step();
            if (retire16 === 1'b1 && firstRetire < 0) begin
                firstRetire = cyc;
                total++;
                if (aluResult16 !== 32'd3) begin
                    bad++;
                    $display("FAIL regs16_x15 alu=%h, want 00000003", aluResult16);
                end
            end
        end
        total++;
        if (firstRetire !== 4 || illegal16 !== 1'b1 || pcOut16 !== 32'h104 || imemReq16 !== 1'b0) begin
            bad++;
            $display("FAIL regs16_x20 retire_cycle=%0d illegal=%b pc=%h req=%b, want 4 1 00000104 0",
                     firstRetire, illegal16, pcOut16, imemReq16);
        end
    endtask

    task automatic test_reset_stall();
        bit ok;
        clearMem();
        imem[0] = NOP;
        imem[1] = 32'h0090_0093;   // ADDI x1,x0,9
        doReset();
        waitRetire(30, ok);
        imemReady = 1'b0;
        repeat (3) step();
        total++;
        if (!ok || imemReq !== 1'b1 || pcOut !== 32'h4) begin
            bad++;
            $display("FAIL fetch_stall ok=%b imem_req=%b pc=%h, want 1 00000004", ok, imemReq, pcOut);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (imemReq !== 1'b0 || pcOut !== 32'h0 || retire !== 1'b0) begin
            bad++;
            $display("FAIL async_reset imem_req=%b pc=%h retire=%b, want 0 00000000 0", imemReq, pcOut, retire);
        end
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        imemReady = 1'b1;
        cyc       = -1;
        waitRetire(30, ok);
        waitRetire(30, ok);
        total++;
        if (!ok || cyc !== 8 || aluResult !== 32'd9 || pcOut !== 32'h8) begin
            bad++;
            $display("FAIL resume ok=%b cycle=%0d alu=%0d pc=%h, want 8 9 00000008", ok, cyc, aluResult, pcOut);
        end
    endtask

    initial begin
        rst         = 1'b0;
        imemReady   = 1'b1;
        imemReady16 = 1'b1;
        dmemReady16 = 1'b0;
        dmemRdata16 = 32'd0;
        dmemReady   = 1'b0;
        dmemRdata   = 32'd0;
        for (int i = 0; i < 64; i++) imem16[i] = 32'd0;
        imem16[0] = 32'h0030_0793;   // ADDI x15,x0,3
        imem16[1] = 32'h0010_0A13;   // ADDI x20,x0,1
        test_reset();
        test_alu_program();
        test_mem_stall();
        test_branch();
        test_shift_compare();
        test_pc_wrap();
        test_illegal();
        test_regs16();
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
